// File: rtl/keypad_pkg.sv
// Shared types and the key map for the 4x4 matrix keypad scanner.
// KEY_MAP is indexed by {row, col}; row 0 is the top row, col 0 the leftmost column.
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} scan_state_t;

  // Entry 15 comes first in the concatenation, so each row reads right-to-left.
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hF, 4'h0, 4'hE,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  function automatic logic [1:0] lowest_col(input logic [3:0] v);
    logic [1:0] idx;
    if (v[0])      idx = 2'd0;
    else if (v[1]) idx = 2'd1;
    else if (v[2]) idx = 2'd2;
    else           idx = 2'd3;
    return idx;
  endfunction

  function automatic logic [3:0] row_onehot(input logic [1:0] r);
    return 4'b0001 << r;
  endfunction

endpackage

// File: rtl/keypad_if.sv
// Row-drive / column-sense and key-output bundle between the scanner and its neighbours.
interface keypad_if;
  logic [3:0] cols;
  logic [3:0] rows;
  logic [3:0] key;
  logic       key_valid;

  modport master (input cols, output rows, output key, output key_valid);
  modport slave  (output cols, input rows, input key, input key_valid);
endinterface

// File: rtl/keypad_decoder.sv
// Combinational (row, col) -> key code lookup.
module keypad_decoder
  import keypad_pkg::*;
(
  input  logic [1:0] row_idx,
  input  logic [1:0] col_idx,
  output logic [3:0] code
);

  assign code = KEY_MAP[{row_idx, col_idx}];

endmodule

// File: rtl/synchronizer.sv
// Two-flop synchronizer for the raw keypad column lines.
module synchronizer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
    end
  end

  assign out = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// Row-scanning 4x4 keypad controller: debounces press and release, and emits
// one key code with a single-cycle key_valid pulse per physical press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES     = 1000,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic     clk,
  input  logic     reset,
  keypad_if.master kp
);

  localparam int CNT_MAX = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

  scan_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       row_q, row_d;
  logic [1:0]       col_q, col_d;
  logic [3:0]       rows_q, rows_d;
  logic [3:0]       key_q, key_d;
  logic             key_valid_q, key_valid_d;
  logic [3:0]       code;
  logic             col_hit;

  keypad_decoder u_decoder (
    .row_idx (row_q),
    .col_idx (col_q),
    .code    (code)
  );

  // Once a column is latched, only that single line matters until the key is released.
  assign col_hit = kp.cols[col_q];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    row_d       = row_q;
    col_d       = col_q;
    key_d       = key_q;
    key_valid_d = 1'b0;
    case (state_q)
      SCAN: begin
        if (cnt_q == SCAN_LAST) begin
          cnt_d = '0;
          if (|kp.cols) begin
            col_d   = lowest_col(kp.cols);
            state_d = DEBOUNCE;
          end else begin
            row_d = row_q + 2'd1;
          end
        end
      end
      DEBOUNCE: begin
        if (!col_hit) begin
          state_d = SCAN;
          row_d   = row_q + 2'd1;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          key_d       = code;
          key_valid_d = 1'b1;
          state_d     = HELD;
          cnt_d       = '0;
        end
      end
      HELD: begin
        cnt_d = '0;
        if (!col_hit) state_d = RELEASE;
      end
      RELEASE: begin
        if (col_hit) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = SCAN;
          row_d   = row_q + 2'd1;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = SCAN;
        cnt_d   = '0;
      end
    endcase
    rows_d = row_onehot(row_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SCAN;
      cnt_q       <= '0;
      row_q       <= 2'd0;
      col_q       <= 2'd0;
      rows_q      <= 4'b0001;
      key_q       <= 4'h0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      row_q       <= row_d;
      col_q       <= col_d;
      rows_q      <= rows_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign kp.rows      = rows_q;
  assign kp.key       = key_q;
  assign kp.key_valid = key_valid_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench: a keypad model driven by rows feeds a real synchronizer into the scanner.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pressed;
  logic [3:0]  raw_cols;
  logic [3:0]  sync_cols;
  logic        kv_prev = 1'b0;
  int          pulse_cnt = 0;
  int          errors = 0;
  int          checks = 0;

  keypad_if kif ();

  always #5 clk = ~clk;

  // Key matrix model: a pressed key connects its row drive to its column line.
  always_comb begin
    raw_cols = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (kif.rows[r] && pressed[r*4+c]) raw_cols[c] = 1'b1;
  end

  synchronizer #(.WIDTH(4)) u_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (raw_cols),
    .out      (sync_cols)
  );

  assign kif.cols = sync_cols;

  keypad_scanner #(.SCAN_CYCLES(4), .DEBOUNCE_CYCLES(8)) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kif)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pulse monitor: counts pulses and flags any back-to-back key_valid.
  always @(posedge clk) begin
    #1;
    if (kif.key_valid === 1'b1) begin
      check("kv_single", 32'(kv_prev), 32'd0);
      pulse_cnt++;
    end
    kv_prev = kif.key_valid;
  end

  initial begin
    reset   = 1'b1;
    pressed = '0;

    // Reset state and idle row rotation
    step(2);
    check("rst_rows", 32'(kif.rows), 32'h1);
    check("rst_key", 32'(kif.key), 32'h0);
    check("rst_kv", 32'(kif.key_valid), 32'h0);
    reset = 1'b0;
    step(4); check("rot_r1", 32'(kif.rows), 32'h2);
    step(4); check("rot_r2", 32'(kif.rows), 32'h4);
    step(4); check("rot_r3", 32'(kif.rows), 32'h8);
    step(4); check("rot_wrap", 32'(kif.rows), 32'h1);

    // Clean press of "5" (r1,c1)
    pressed[5] = 1'b1;
    step(15); check("p5_before", 32'(kif.key_valid), 32'h0);
    step(1);  check("p5_kv", 32'(kif.key_valid), 32'h1);
    check("p5_key", 32'(kif.key), 32'h5);
    step(1);  check("p5_kv_drop", 32'(kif.key_valid), 32'h0);
    step(23);
    check("p5_row_held", 32'(kif.rows), 32'h2);
    check("p5_pulses", 32'(pulse_cnt), 32'd1);
    pressed[5] = 1'b0;
    step(10); check("p5_rel_hold", 32'(kif.rows), 32'h2);
    step(1);  check("p5_rel_next", 32'(kif.rows), 32'h4);
    check("p5_key_kept", 32'(kif.key), 32'h5);

    // Bouncy press of "F" (r3,c2)
    step(5);
    pressed[14] = 1'b1; step(1);
    pressed[14] = 1'b0; step(1);
    pressed[14] = 1'b1; step(1);
    pressed[14] = 1'b0; step(1);
    check("pF_reject_row", 32'(kif.rows), 32'h1);
    check("pF_reject_cnt", 32'(pulse_cnt), 32'd1);
    pressed[14] = 1'b1;
    step(23); check("pF_before", 32'(kif.key_valid), 32'h0);
    step(1);  check("pF_kv", 32'(kif.key_valid), 32'h1);
    check("pF_key", 32'(kif.key), 32'hF);
    check("pF_pulses", 32'(pulse_cnt), 32'd2);
    pressed[14] = 1'b0;
    step(10); check("pF_rel_hold", 32'(kif.rows), 32'h8);
    step(1);  check("pF_rel_wrap", 32'(kif.rows), 32'h1);

    // Press "A" (r0,c3) then bounce on release
    pressed[3] = 1'b1;
    step(11); check("pA_before", 32'(kif.key_valid), 32'h0);
    step(1);  check("pA_kv", 32'(kif.key_valid), 32'h1);
    check("pA_key", 32'(kif.key), 32'hA);
    pressed[3] = 1'b0; step(3);
    pressed[3] = 1'b1; step(2);
    pressed[3] = 1'b0;
    step(10); check("pA_rel_hold", 32'(kif.rows), 32'h1);
    step(1);  check("pA_rel_next", 32'(kif.rows), 32'h2);
    check("pA_key_kept", 32'(kif.key), 32'hA);
    check("pA_pulses", 32'(pulse_cnt), 32'd3);

    // Simultaneous "7" and "9" on r2, then "C" while held
    pressed[8]  = 1'b1;
    pressed[10] = 1'b1;
    step(15); check("p79_before", 32'(kif.key_valid), 32'h0);
    step(1);  check("p79_kv", 32'(kif.key_valid), 32'h1);
    check("p79_key", 32'(kif.key), 32'h7);
    pressed[11] = 1'b1;
    step(20);
    check("pC_pulses", 32'(pulse_cnt), 32'd4);
    check("pC_key", 32'(kif.key), 32'h7);
    check("pC_row", 32'(kif.rows), 32'h4);
    pressed = '0;
    step(10); check("p79_rel_hold", 32'(kif.rows), 32'h4);
    step(1);  check("p79_rel_next", 32'(kif.rows), 32'h8);

    // Reset at debounce count 5 while "E" (r3,c0) is pressed
    pressed[12] = 1'b1;
    step(9);
    reset   = 1'b1;
    pressed = '0;
    step(1);
    check("mrst_rows", 32'(kif.rows), 32'h1);
    check("mrst_key", 32'(kif.key), 32'h0);
    check("mrst_kv", 32'(kif.key_valid), 32'h0);
    reset = 1'b0;
    step(1); check("mrst_kv_after", 32'(kif.key_valid), 32'h0);
    step(3); check("mrst_restart", 32'(kif.rows), 32'h2);
    check("mrst_pulses", 32'(pulse_cnt), 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
